garbage_queue_ctrl: RTL

Schedules incoming garbage lines for the user playfield. Queues garbage batches received over the LAN link. Cancels queued garbage against the user's own line clears and forwards any surplus as outgoing attack. Releases the remaining garbage into the playfield one row per cycle when a piece locks. It also drives the pending-garbage meter in the PENDING region of the display, which is 20 ticks tall (one per playfield row).

---
 rtl/garbage_queue_ctrl.sv | 197 +++++++++++++++++++
 1 files changed

// File: rtl/garbage_queue_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : garbage_queue_ctrl
// Purpose  : Queues incoming garbage batches from the LAN link. Cancels them
//            against the user's line clears and forwards any surplus as an
//            outgoing attack. On a lock it releases queued rows into the
//            playfield one row per cycle and drives the pending meter.
// Revision : 1.0 - initial release
// ============================================================================
module garbage_queue_ctrl #(
  parameter int DEPTH      = 8,
  parameter int INSERT_CAP = 8,
  parameter int METER_MAX  = 20
) (
  input  logic       clk,
  input  logic       rst_l,
  input  logic       recv_valid,
  input  logic [3:0] recv_lines,
  input  logic [3:0] recv_hole,
  output logic       recv_drop,
  output logic       cmd_ready,
  input  logic       clear_valid,
  input  logic [3:0] clear_lines,
  input  logic       lock_valid,
  output logic       send_valid,
  output logic [3:0] send_lines,
  output logic       insert_row,
  output logic [3:0] insert_hole,
  output logic [6:0] pending_total,
  output logic [4:0] pending_ticks
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam int IW = $clog2(INSERT_CAP + 1);

  localparam logic [CW-1:0] C_DEPTH     = CW'(DEPTH);
  localparam logic [IW-1:0] C_CAP       = IW'(INSERT_CAP);
  localparam logic [6:0]    C_METER_MAX = 7'(METER_MAX);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_CANCEL = 2'd1,
    S_INSERT = 2'd2
  } state_t;

  state_t r_state;
  state_t w_state_next;

  logic [3:0]    r_lines_mem [DEPTH];
  logic [3:0]    r_hole_mem  [DEPTH];
  logic [PW-1:0] r_head;
  logic [PW-1:0] r_tail;
  logic [CW-1:0] r_count;
  logic [3:0]    r_rem;
  logic [IW-1:0] r_inserted;
  logic [6:0]    r_total;

  logic          w_full;
  logic          w_recv_ok;
  logic          w_enq;
  logic [3:0]    w_hole_clamp;
  logic [3:0]    w_head_lines;
  logic [3:0]    w_head_hole;
  logic          w_pop;
  logic          w_head_wr;
  logic [3:0]    w_head_wr_val;
  logic [3:0]    w_rem_next;
  logic [IW-1:0] w_ins_next;
  logic [3:0]    w_dec;
  logic [7:0]    w_total_add;
  logic [6:0]    w_total_next;

  // Fullness comes from registered state only, so a same-cycle pop never makes room.
  assign w_full       = (r_count == C_DEPTH);
  assign w_recv_ok    = recv_valid && (recv_lines != 4'd0);
  assign w_enq        = w_recv_ok && !w_full;
  assign recv_drop    = w_recv_ok && w_full;
  assign w_hole_clamp = (recv_hole > 4'd9) ? 4'd9 : recv_hole;
  assign w_head_lines = r_lines_mem[r_head];
  assign w_head_hole  = r_hole_mem[r_head];

  // Pending sum: add the accepted batch, remove cancelled/inserted lines, floor at 0.
  assign w_total_add   = {1'b0, r_total} + 8'(w_enq ? recv_lines : 4'd0);
  assign w_total_next  = (w_total_add >= 8'(w_dec)) ? 7'(w_total_add - 8'(w_dec)) : 7'd0;
  assign pending_total = r_total;
  assign pending_ticks = (r_total > C_METER_MAX) ? 5'(C_METER_MAX) : r_total[4:0];

  // Next-state and output decode for the command FSM.
  always_comb begin
    w_state_next  = r_state;
    w_pop         = 1'b0;
    w_head_wr     = 1'b0;
    w_head_wr_val = 4'd0;
    w_rem_next    = r_rem;
    w_ins_next    = r_inserted;
    w_dec         = 4'd0;
    cmd_ready     = 1'b0;
    send_valid    = 1'b0;
    send_lines    = 4'd0;
    insert_row    = 1'b0;
    insert_hole   = 4'd0;
    case (r_state)
      S_IDLE: begin
        cmd_ready = 1'b1;
        if (clear_valid) begin
          // A clear always wins over a simultaneous lock.
          if (clear_lines != 4'd0) begin
            w_rem_next   = clear_lines;
            w_state_next = S_CANCEL;
          end
        end else if (lock_valid && (r_count != '0)) begin
          w_ins_next   = '0;
          w_state_next = S_INSERT;
        end
      end
      S_CANCEL: begin
        if (r_count == '0) begin
          send_valid   = 1'b1;
          send_lines   = r_rem;
          w_rem_next   = 4'd0;
          w_state_next = S_IDLE;
        end else if (w_head_lines <= r_rem) begin
          w_pop      = 1'b1;
          w_dec      = w_head_lines;
          w_rem_next = r_rem - w_head_lines;
          if (w_head_lines == r_rem) begin
            w_state_next = S_IDLE;
          end
        end else begin
          w_head_wr     = 1'b1;
          w_head_wr_val = w_head_lines - r_rem;
          w_dec         = r_rem;
          w_rem_next    = 4'd0;
          w_state_next  = S_IDLE;
        end
      end
      S_INSERT: begin
        insert_row  = 1'b1;
        insert_hole = w_head_hole;
        w_dec       = 4'd1;
        w_ins_next  = r_inserted + IW'(1);
        if (w_head_lines <= 4'd1) begin
          w_pop = 1'b1;
        end else begin
          w_head_wr     = 1'b1;
          w_head_wr_val = w_head_lines - 4'd1;
        end
        // Stop at the per-lock cap or when the last registered entry pops.
        if ((w_ins_next == C_CAP) || (w_pop && (r_count == CW'(1)))) begin
          w_state_next = S_IDLE;
        end
      end
      default: begin
        w_state_next = S_IDLE;
      end
    endcase
  end

  // FSM state, pointers, counters and the pending sum.
  always_ff @(posedge clk or negedge rst_l) begin
    if (!rst_l) begin
      r_state    <= S_IDLE;
      r_head     <= '0;
      r_tail     <= '0;
      r_count    <= '0;
      r_rem      <= 4'd0;
      r_inserted <= '0;
      r_total    <= 7'd0;
    end else begin
      r_state    <= w_state_next;
      r_rem      <= w_rem_next;
      r_inserted <= w_ins_next;
      r_total    <= w_total_next;
      r_count    <= r_count + CW'(w_enq) - CW'(w_pop);
      if (w_enq) begin
        r_tail <= r_tail + PW'(1);
      end
      if (w_pop) begin
        r_head <= r_head + PW'(1);
      end
    end
  end

  // Batch storage: new batches land at the tail, partial consumption rewrites the head.
  always_ff @(posedge clk) begin
    if (w_enq) begin
      r_lines_mem[r_tail] <= recv_lines;
      r_hole_mem[r_tail]  <= w_hole_clamp;
    end
    if (w_head_wr) begin
      r_lines_mem[r_head] <= w_head_wr_val;
    end
  end

endmodule
`default_nettype wire
